// File: rtl/inst_loader.sv
// Program loader: parses a length-prefixed, big-endian byte image from the UART
// receiver and writes the 32-bit instruction words into instruction BRAM.
module inst_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic [31:0]       word_count,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_shift;
  logic [ADDR_W-1:0]   r_widx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_word_count;

  logic                w_active;
  logic                w_take;
  logic                w_abort;
  logic                w_word_end;
  logic                w_final;
  logic [31:0]         w_asm;

  assign w_active   = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_take     = w_active && rx_valid && !rx_ferr;
  assign w_abort    = w_active && rx_valid && rx_ferr;
  assign w_word_end = w_take && (r_bcnt == 2'd3);
  // Earlier bytes shift up, so the first byte of a word lands in the MSB.
  assign w_asm      = {r_shift, rx_data};
  assign w_final    = (r_state == S_DATA) && w_word_end &&
                      ({{(32-ADDR_W){1'b0}}, r_widx} == (r_word_count - 32'd1));

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_HDR;
      S_HDR: begin
        if (w_abort) begin
          w_next = S_ERR;
        end else if (w_word_end) begin
          if (w_asm == 32'd0)                   w_next = S_DONE;
          else if ({1'b0, w_asm} > DEPTH)       w_next = S_ERR;
          else                                  w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_abort)      w_next = S_ERR;
        else if (w_final) w_next = S_DONE;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte assembly and the registered BRAM write port; the write pulse lands
  // the cycle after the word's last byte without stalling the next byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bcnt       <= 2'd0;
      r_shift      <= 24'd0;
      r_widx       <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= 32'd0;
      r_word_count <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (w_take) begin
        r_shift <= w_asm[23:0];
        r_bcnt  <= r_bcnt + 2'd1;
      end
      if ((r_state == S_HDR) && w_word_end) r_word_count <= w_asm;
      if ((r_state == S_DATA) && w_word_end) begin
        r_we    <= 1'b1;
        r_waddr <= r_widx;
        r_wdata <= w_asm;
        r_widx  <= r_widx + 1'b1;
      end
    end
  end

  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign word_count = r_word_count;
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_ERR);

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Program loader upstream of the instruction fetch stage.
- Active while the core is in LOAD mode. Consumes the byte stream from uart_rx and parses a length-prefixed program image.
- Assembles 32-bit big-endian instruction words and writes them sequentially into instruction BRAM through a single write port.
- Raises done once the whole image is stored; the core's mode controller uses done to move LOAD -> EXEC.

Parameters:
- ADDR_W, 15, instruction memory word-address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- start  in  1  level; high while core mode == LOAD
- rx_data  in  8  received byte from uart_rx
- rx_valid  in  1  one-cycle strobe; rx_data valid
- rx_ferr  in  1  framing error flag accompanying rx_valid
- we  out  1  instruction BRAM write enable, one-cycle pulse
- waddr  out  ADDR_W  word index being written
- wdata  out  32  instruction word
- word_count  out  32  length field from header
- done  out  1  image fully loaded, sticky
- err  out  1  load aborted, sticky

Behaviour:
- Reset: one clock, synchronous active-low (rstn low at a posedge). On reset:
  - we=0, waddr=0, wdata=0, word_count=0, done=0, err=0
  - state=IDLE, byte counter=0, word index=0
  - reset mid-load discards any partial word; no write is issued.
- States: IDLE, HDR, DATA, DONE, ERR.
- IDLE: rx_valid ignored. start high -> HDR on the next edge; first accepted byte is the first byte after the transition.
- Byte assembly: 2-bit byte counter 0..3. Byte k goes to bits [31-8k -: 8] (first byte = MSB). Counter wraps 3 -> 0 on each 4th byte.
- HDR: after the 4th byte, word_count = assembled value, then:
  - word_count == 0 -> DONE
  - word_count > DEPTH -> ERR
  - else -> DATA
- DATA write timing: on the 4th byte of a word, we=1 for exactly one cycle, the cycle after that byte's rx_valid.
  - waddr = current word index; wdata = assembled word.
  - Word index increments after the write.
- DATA exit: when the write of index word_count-1 issues, go to DONE. done rises in the same cycle as that final we pulse.
- rx_ferr high with rx_valid in HDR or DATA -> ERR. That byte is not used; no write issued for the partial word.
- DONE: done=1 held until reset; all further rx_valid ignored; we stays 0.
- ERR: err=1 held until reset; done stays 0; we stays 0.
- start deasserted in HDR/DATA: ignored; loading continues. Only rstn aborts.
- Back-to-back rx_valid (consecutive cycles) must be accepted without loss. The write pulse never blocks byte acceptance.
- No latency requirement beyond the above; throughput is at least 1 byte/cycle.
- Addresses never wrap: the overflow check guarantees word index < DEPTH.

Test Plan:
- start=1; bytes 00 00 00 02, DE AD BE EF, 12 34 56 78 ->
  - we pulses: (waddr 0, wdata 0xDEADBEEF), then (waddr 1, wdata 0x12345678)
  - word_count=2; done=1 with the second pulse; err=0.
- start=1; bytes 00 00 00 00 -> no we pulse; done=1 one cycle after the 4th byte; later bytes ignored.
- ADDR_W=4; header 00 00 00 11 (17 > 16) -> err=1, done=0, no we.
- Header 00 00 00 01, then AA BB with rx_ferr=1 on BB -> err=1, no we; further bytes ignored.
- Bytes with rx_valid while start=0 -> ignored. Then assert start and send a 1-word image 00 00 00 01 01 02 03 04 -> we at waddr 0 with 0x01020304; done=1.
- Reset mid-load:
  - rstn low after 2 data bytes of word 0 -> all outputs return to reset values.
  - Reload with a 1-word image 00 00 00 01 CA FE BA BE -> waddr 0, wdata 0xCAFEBABE, done=1.
